// File: rtl/vx_data_arbiter_pkg.sv
// Shared types for the data-store arbiter: FSM state encoding and starve-counter sizing.
package vx_data_arbiter_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } arb_state_e;

  // Bits needed to count 0..limit inclusive.
  function automatic int unsigned starve_cnt_width(input int unsigned limit);
    return unsigned'($clog2(limit + 1));
  endfunction

endpackage

// File: rtl/vx_data_arbiter_init.sv
// Line-sweep counter that walks every data-store line once after reset so the store
// starts zeroed; advances only on enabled (non-stalled) cycles.
module vx_data_arb_init #(
  parameter int unsigned LINES_PER_BANK = 64,
  parameter int unsigned CNT_W          = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic [CNT_W-1:0] line,
  output logic             last
);

  assign last = (line == CNT_W'(LINES_PER_BANK - 1));

  // Wrap to zero after the final line so a later re-sweep starts clean.
  always_ff @(posedge clk) begin
    if (reset) begin
      line <= '0;
    end else if (en) begin
      line <= last ? '0 : line + CNT_W'(1);
    end
  end

endmodule

// File: rtl/vx_data_arbiter.sv
// Arbitrates fill and core requests onto a single data-store command port with
// bounded core starvation. Optional post-reset zeroing sweep: VX_DATA_ARB_INIT_EN.
module vx_data_arbiter
  import vx_data_arbiter_pkg::*;
#(
  parameter  int unsigned LINE_ADDR_WIDTH  = 8,
  parameter  int unsigned LINES_PER_BANK   = 64,
  parameter  int unsigned NUM_PORTS        = 1,
  parameter  int unsigned WORD_SIZE        = 4,
  parameter  int unsigned WORDS_PER_LINE   = 4,
  parameter  int unsigned WORD_SELECT_BITS = 2,
  parameter  int unsigned STARVE_LIMIT     = 4,
  localparam int unsigned WORD_WIDTH       = WORD_SIZE * 8,
  localparam int unsigned LINE_WIDTH       = WORDS_PER_LINE * WORD_WIDTH
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  fill_valid,
  output logic                                  fill_ready,
  input  logic [LINE_ADDR_WIDTH-1:0]            fill_addr,
  input  logic [LINE_WIDTH-1:0]                 fill_data,
  input  logic                                  core_valid,
  output logic                                  core_ready,
  input  logic                                  core_rw,
  input  logic [LINE_ADDR_WIDTH-1:0]            core_addr,
  input  logic [NUM_PORTS*WORD_SELECT_BITS-1:0] core_wsel,
  input  logic [NUM_PORTS-1:0]                  core_pmask,
  input  logic [NUM_PORTS*WORD_SIZE-1:0]        core_byteen,
  input  logic [NUM_PORTS*WORD_WIDTH-1:0]       core_data,
  input  logic                                  stall,
  output logic                                  da_read,
  output logic                                  da_fill,
  output logic                                  da_write,
  output logic [LINE_ADDR_WIDTH-1:0]            da_addr,
  output logic [NUM_PORTS*WORD_SELECT_BITS-1:0] da_wsel,
  output logic [NUM_PORTS-1:0]                  da_pmask,
  output logic [NUM_PORTS*WORD_SIZE-1:0]        da_byteen,
  output logic [LINE_WIDTH-1:0]                 da_fill_data,
  output logic [NUM_PORTS*WORD_WIDTH-1:0]       da_write_data,
  input  logic [NUM_PORTS*WORD_WIDTH-1:0]       da_read_data,
  output logic                                  rsp_valid,
  output logic [NUM_PORTS*WORD_WIDTH-1:0]       rsp_data,
  output logic                                  init_done
);

  localparam int unsigned STARVE_W = starve_cnt_width(STARVE_LIMIT);

  logic                       in_init;
  logic                       run_ok;
  logic [LINE_ADDR_WIDTH-1:0] init_addr;
  logic [STARVE_W-1:0]        starve_cnt;
  logic                       starve_full;
  logic                       core_win;
  logic                       fill_win;
  logic                       grant_ok;
  logic                       fill_xfer;
  logic                       core_xfer;
  logic                       init_step;

`ifdef VX_DATA_ARB_INIT_EN
  localparam int unsigned LINE_SELECT_BITS = $clog2(LINES_PER_BANK);
  localparam int unsigned CNT_W = (LINE_SELECT_BITS > 0) ? LINE_SELECT_BITS : 1;

  arb_state_e       state;
  logic [CNT_W-1:0] init_line;
  logic             init_last;

  vx_data_arb_init #(
    .LINES_PER_BANK(LINES_PER_BANK),
    .CNT_W         (CNT_W)
  ) u_init (
    .clk  (clk),
    .reset(reset),
    .en   (init_step),
    .line (init_line),
    .last (init_last)
  );

  // INIT -> RUN after the last line is written; init_done rises with the transition.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= INIT;
      init_done <= 1'b0;
    end else if (state == INIT && !stall && init_last) begin
      state     <= RUN;
      init_done <= 1'b1;
    end
  end

  assign in_init   = (state == INIT) && !reset;
  assign run_ok    = (state == RUN);
  assign init_addr = LINE_ADDR_WIDTH'(init_line);
`else
  assign in_init   = 1'b0;
  assign run_ok    = 1'b1;
  assign init_addr = '0;
  assign init_done = 1'b1;
`endif

  // Fill wins unless the core has already lost STARVE_LIMIT times in a row.
  assign starve_full = (starve_cnt == STARVE_W'(STARVE_LIMIT));
  assign core_win    = core_valid && (!fill_valid || starve_full);
  assign fill_win    = fill_valid && !core_win;
  assign grant_ok    = !reset && !stall && run_ok;
  assign fill_ready  = grant_ok && fill_win;
  assign core_ready  = grant_ok && core_win;
  assign fill_xfer   = fill_ready;
  assign core_xfer   = core_ready;
  assign init_step   = in_init && !stall;

  assign da_fill       = fill_xfer || init_step;
  assign da_write      = core_xfer && core_rw;
  assign da_read       = core_xfer && !core_rw;
  assign da_addr       = in_init ? init_addr : (fill_win ? fill_addr : core_addr);
  assign da_fill_data  = in_init ? '0 : fill_data;
  assign da_wsel       = core_wsel;
  assign da_pmask      = core_pmask;
  assign da_byteen     = core_byteen;
  assign da_write_data = core_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (!core_valid || core_xfer) begin
      starve_cnt <= '0;
    end else if (fill_xfer && !starve_full) begin
      starve_cnt <= starve_cnt + STARVE_W'(1);
    end
  end

  // Read data returns one cycle after the read command.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= da_read;
      if (da_read) begin
        rsp_data <= da_read_data;
      end
    end
  end

endmodule

// File: tb/tb_vx_data_arbiter.sv
// Scoreboard bench for vx_data_arbiter: expected commands/responses are queued by the
// stimulus and consumed by a negedge monitor. Covers the sweep when VX_DATA_ARB_INIT_EN is set.
module tb_vx_data_arbiter;

  typedef struct packed {
    logic [2:0]   strb;   // {fill, write, read}
    logic [7:0]   addr;
    logic [127:0] data;
    logic [3:0]   byteen;
  } cmd_t;

  localparam logic [2:0] S_FILL = 3'b100;
  localparam logic [2:0] S_WR   = 3'b010;
  localparam logic [2:0] S_RD   = 3'b001;

  logic         clk = 1'b0;
  logic         reset;
  logic         fill_valid, fill_ready;
  logic [7:0]   fill_addr;
  logic [127:0] fill_data;
  logic         core_valid, core_ready, core_rw;
  logic [7:0]   core_addr;
  logic [1:0]   core_wsel;
  logic [0:0]   core_pmask;
  logic [3:0]   core_byteen;
  logic [31:0]  core_data;
  logic         stall;
  logic         da_read, da_fill, da_write;
  logic [7:0]   da_addr;
  logic [1:0]   da_wsel;
  logic [0:0]   da_pmask;
  logic [3:0]   da_byteen;
  logic [127:0] da_fill_data;
  logic [31:0]  da_write_data;
  logic [31:0]  da_read_data;
  logic         rsp_valid;
  logic [31:0]  rsp_data;
  logic         init_done;

  int   checks = 0;
  int   errors = 0;
  cmd_t        cmd_q[$];
  logic [31:0] rsp_q[$];

  vx_data_arbiter dut (
    .clk(clk), .reset(reset),
    .fill_valid(fill_valid), .fill_ready(fill_ready), .fill_addr(fill_addr), .fill_data(fill_data),
    .core_valid(core_valid), .core_ready(core_ready), .core_rw(core_rw), .core_addr(core_addr),
    .core_wsel(core_wsel), .core_pmask(core_pmask), .core_byteen(core_byteen), .core_data(core_data),
    .stall(stall), .da_read(da_read), .da_fill(da_fill), .da_write(da_write), .da_addr(da_addr),
    .da_wsel(da_wsel), .da_pmask(da_pmask), .da_byteen(da_byteen), .da_fill_data(da_fill_data),
    .da_write_data(da_write_data), .da_read_data(da_read_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .init_done(init_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push_cmd(input logic [2:0] s, input logic [7:0] a, input logic [127:0] d,
                          input logic [3:0] b);
    cmd_t c;
    c.strb = s; c.addr = a; c.data = d; c.byteen = b;
    cmd_q.push_back(c);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every data-store strobe and every response must match the next expectation.
  always @(negedge clk) begin
    cmd_t e;
    if (da_fill || da_read || da_write) begin
      if (cmd_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_cmd actual=%b addr=%0h required=none", {da_fill, da_write, da_read}, da_addr);
      end else begin
        e = cmd_q.pop_front();
        chk("cmd_strobe", 128'({da_fill, da_write, da_read}), 128'(e.strb));
        chk("cmd_addr", 128'(da_addr), 128'(e.addr));
        if (e.strb == S_FILL) chk("cmd_fill_data", da_fill_data, e.data);
        if (e.strb == S_WR) begin
          chk("cmd_write_data", 128'(da_write_data), e.data);
          chk("cmd_byteen", 128'(da_byteen), 128'(e.byteen));
        end
      end
    end
    if (rsp_valid) begin
      if (rsp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_rsp actual=%0h required=none", rsp_data);
      end else begin
        chk("rsp_data", 128'(rsp_data), 128'(rsp_q.pop_front()));
      end
    end
  end

`ifdef VX_DATA_ARB_INIT_EN
  // Runs from the first cycle after reset release; optional 3-cycle stall at stall_at.
  task automatic sweep(input int stall_at, input int exp_done);
    int done_cyc = -1;
    for (int l = 0; l < 64; l++) push_cmd(S_FILL, 8'(l), 128'h0, 4'h0);
    for (int cyc = 0; cyc < 300; cyc++) begin
      stall      = (stall_at >= 0) && (cyc >= stall_at) && (cyc < stall_at + 3);
      fill_valid = (cyc < 60);
      @(negedge clk);
      if (init_done) begin
        done_cyc = cyc;
        break;
      end
      if (cyc < 60) chk("init_fill_ready", 128'(fill_ready), 128'h0);
      if (stall) chk("init_stall_hold", 128'(da_fill), 128'h0);
      if (cyc < 2) chk("init_no_rsp", 128'(rsp_valid), 128'h0);
      step();
    end
    chk("init_done_cycle", 128'(done_cyc), 128'(exp_done));
    stall = 1'b0;
    fill_valid = 1'b0;
    step();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    string pat = "FFFFCFFFFC";
    reset = 1'b1; stall = 1'b0;
    fill_valid = 1'b1; fill_addr = 8'h00; fill_data = '0;
    core_valid = 1'b1; core_rw = 1'b0; core_addr = 8'h00;
    core_wsel = 2'd0; core_pmask = 1'b1; core_byteen = 4'hf; core_data = '0;
    da_read_data = '0;

    // Reset: nothing granted or strobed even with both requesters valid.
    repeat (3) begin
      @(negedge clk);
      chk("rst_fill_ready", 128'(fill_ready), 128'h0);
      chk("rst_core_ready", 128'(core_ready), 128'h0);
      chk("rst_strobes", 128'({da_fill, da_write, da_read}), 128'h0);
      chk("rst_rsp_valid", 128'(rsp_valid), 128'h0);
      chk("rst_rsp_data", 128'(rsp_data), 128'h0);
    end
    @(posedge clk); #1;
    reset = 1'b0; fill_valid = 1'b0; core_valid = 1'b0;

`ifdef VX_DATA_ARB_INIT_EN
    sweep(-1, 64);
`else
    @(negedge clk);
    chk("init_done_const", 128'(init_done), 128'h1);
    step();
`endif

    // Read at addr 5: one-cycle latency, single pulse.
    core_valid = 1'b1; core_rw = 1'b0; core_addr = 8'd5; da_read_data = 32'hDEADBEEF;
    push_cmd(S_RD, 8'd5, '0, 4'h0); rsp_q.push_back(32'hDEADBEEF);
    @(negedge clk);
    chk("read_core_ready", 128'(core_ready), 128'h1);
    chk("read_lat0", 128'(rsp_valid), 128'h0);
    step();
    core_valid = 1'b0; da_read_data = '0;
    @(negedge clk);
    chk("read_lat1", 128'(rsp_valid), 128'h1);
    chk("read_lat1_data", 128'(rsp_data), 128'hDEADBEEF);
    step();
    @(negedge clk);
    chk("read_pulse_end", 128'(rsp_valid), 128'h0);
    step();

    // Back-to-back write then read; only the read responds.
    core_valid = 1'b1; core_rw = 1'b1; core_addr = 8'd7; core_data = 32'h11223344;
    core_byteen = 4'h3; core_wsel = 2'd2;
    push_cmd(S_WR, 8'd7, 128'h11223344, 4'h3);
    @(negedge clk);
    chk("b2b_write", 128'(da_write), 128'h1);
    step();
    core_rw = 1'b0; core_addr = 8'd8; core_byteen = 4'hf; da_read_data = 32'hCAFEF00D;
    push_cmd(S_RD, 8'd8, '0, 4'h0); rsp_q.push_back(32'hCAFEF00D);
    @(negedge clk);
    chk("b2b_read", 128'(da_read), 128'h1);
    step();
    core_valid = 1'b0;
    repeat (3) step();

    // Starvation: both held valid, expect F,F,F,F,C repeating.
    fill_valid = 1'b1; fill_addr = 8'h20; fill_data = 128'h0123456789ABCDEF_FEDCBA9876543210;
    core_valid = 1'b1; core_rw = 1'b0; core_addr = 8'h30; da_read_data = 32'h0BADF00D;
    for (int i = 0; i < 10; i++) begin
      if (pat[i] == "F") begin
        push_cmd(S_FILL, 8'h20, 128'h0123456789ABCDEF_FEDCBA9876543210, 4'h0);
      end else begin
        push_cmd(S_RD, 8'h30, '0, 4'h0);
        rsp_q.push_back(32'h0BADF00D);
      end
      @(negedge clk);
      chk("starve_fill_ready", 128'(fill_ready), 128'(pat[i] == "F"));
      chk("starve_core_ready", 128'(core_ready), 128'(pat[i] == "C"));
      step();
    end
    fill_valid = 1'b0; core_valid = 1'b0;
    repeat (2) step();

    // Stall in RUN blocks both; on release the fill wins the simultaneous request.
    fill_valid = 1'b1; core_valid = 1'b1; stall = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("stall_fill_ready", 128'(fill_ready), 128'h0);
      chk("stall_core_ready", 128'(core_ready), 128'h0);
      step();
    end
    stall = 1'b0;
    push_cmd(S_FILL, 8'h20, 128'h0123456789ABCDEF_FEDCBA9876543210, 4'h0);
    @(negedge clk);
    chk("simul_fill_wins", 128'(fill_ready), 128'h1);
    chk("simul_core_loses", 128'(core_ready), 128'h0);
    step();
    fill_valid = 1'b0; core_valid = 1'b0;
    repeat (2) step();

    // Read presented while reset is asserted: no command, no response afterwards.
    core_valid = 1'b1; core_rw = 1'b0; core_addr = 8'd9; da_read_data = 32'h12345678; reset = 1'b1;
    @(negedge clk);
    chk("rstrun_core_ready", 128'(core_ready), 128'h0);
    chk("rstrun_da_read", 128'(da_read), 128'h0);
    step();
    reset = 1'b0; core_valid = 1'b0;
`ifdef VX_DATA_ARB_INIT_EN
    sweep(10, 67);
`else
    repeat (2) begin
      @(negedge clk);
      chk("rstrun_no_rsp", 128'(rsp_valid), 128'h0);
      step();
    end
`endif

    repeat (3) step();
    chk("cmd_q_empty", 128'(cmd_q.size()), 128'h0);
    chk("rsp_q_empty", 128'(rsp_q.size()), 128'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
